// File: rtl/j11_bus_pkg.sv
// Shared DCJ11 bus definitions: AIO and bank-select codes, initiator state
// encodings and the high-address word packing used by initiator and checkers.
package j11_bus_pkg;

  localparam logic [3:0] AIO_NIO          = 4'b1111;
  localparam logic [3:0] AIO_GP_READ      = 4'b1110;
  localparam logic [3:0] AIO_REQUEST_READ = 4'b1100;
  localparam logic [3:0] AIO_DATA_READ    = 4'b1001;
  localparam logic [3:0] AIO_DEMAND_READ  = 4'b1000;
  localparam logic [3:0] AIO_GP_WRITE     = 4'b0101;
  localparam logic [3:0] AIO_BYTE_WRITE   = 4'b0011;
  localparam logic [3:0] AIO_WORD_WRITE   = 4'b0001;

  localparam logic [1:0] BS_MEM = 2'b00;
  localparam logic [1:0] BS_SYS = 2'b01;
  localparam logic [1:0] BS_EXT = 2'b10;
  localparam logic [1:0] BS_INT = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ADDR_LO = 3'd1;
  localparam state_t ST_ADDR_HI = 3'd2;
  localparam state_t ST_STRB    = 3'd3;
  localparam state_t ST_RECOVER = 3'd4;

  // Second address word: A20 on bit 0, BS on 7:6, A21 on 8, A19..A16 on 9..12.
  function automatic logic [15:0] pack_addr_hi(input logic [21:0] addr, input logic [1:0] bs);
    logic [15:0] word;
    word       = 16'h0000;
    word[0]    = addr[20];
    word[6]    = bs[0];
    word[7]    = bs[1];
    word[8]    = addr[21];
    word[9]    = addr[19];
    word[10]   = addr[18];
    word[11]   = addr[17];
    word[12]   = addr[16];
    return word;
  endfunction

endpackage

// File: rtl/j11_bus_initiator_if.sv
// DCJ11 bus pin bundle between a bus initiator (CPU side) and a responder.
interface j11_bus_initiator_if;
  logic [15:0] dal_o;
  logic        dal_oe;
  logic [15:0] dal_i;
  logic [3:0]  aio_o;
  logic        ale_n;
  logic        sctl_n;
  logic        bufctl_n;
  logic        cont_n;
  logic        nxm_n;

  modport master (
    output dal_o, dal_oe, aio_o, ale_n, sctl_n, bufctl_n,
    input  dal_i, cont_n, nxm_n
  );

  modport slave (
    input  dal_o, dal_oe, aio_o, ale_n, sctl_n, bufctl_n,
    output dal_i, cont_n, nxm_n
  );
endinterface

// File: rtl/j11_bus_initiator.sv
// DCJ11 bus cycle generator: turns one request into an ALE/SCTL/BUFCTL cycle
// with multiplexed DAL and returns read data, NXM and timeout status.
module j11_bus_initiator
  import j11_bus_pkg::*;
#(
  parameter int unsigned T_ADDR_LO = 2,
  parameter int unsigned T_ADDR_HI = 2,
  parameter int unsigned T_STRB    = 4,
  parameter int unsigned T_RECOVER = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk_x3,
  input  logic        rstb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_aio,
  input  logic [1:0]  req_bs,
  input  logic [21:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_nxm,
  output logic        resp_timeout,
  j11_bus_initiator_if.master bus
);

  // The strobe shares the timeout count; a minimum longer than TIMEOUT is clipped.
  localparam int unsigned STRB_MIN     = (T_STRB > TIMEOUT) ? TIMEOUT : T_STRB;
  localparam logic [7:0]  LOAD_ADDR_LO = 8'(T_ADDR_LO - 1);
  localparam logic [7:0]  LOAD_ADDR_HI = 8'(T_ADDR_HI - 1);
  localparam logic [7:0]  LOAD_STRB    = 8'(TIMEOUT - 1);
  localparam logic [7:0]  LOAD_RECOVER = 8'(T_RECOVER - 1);
  localparam logic [7:0]  STRB_MIN_CNT = 8'(TIMEOUT - STRB_MIN);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [3:0]  aio_r, aio_s;
  logic [1:0]  bs_r, bs_s;
  logic [21:0] addr_r, addr_s;
  logic [15:0] wdata_r, wdata_s;
  logic        accept_s;
  logic        strb_end_s;

  logic [15:0] dal_o_r, dal_o_s;
  logic        dal_oe_r, dal_oe_s;
  logic [3:0]  aio_o_r, aio_o_s;
  logic        ale_n_r, ale_n_s;
  logic        sctl_n_r, sctl_n_s;
  logic        bufctl_n_r, bufctl_n_s;

  assign bus.dal_o    = dal_o_r;
  assign bus.dal_oe   = dal_oe_r;
  assign bus.aio_o    = aio_o_r;
  assign bus.ale_n    = ale_n_r;
  assign bus.sctl_n   = sctl_n_r;
  assign bus.bufctl_n = bufctl_n_r;

  // Next state and down-counter; in STRB the counter doubles as the wait timer.
  always_comb begin
    accept_s   = req_valid & req_ready;
    strb_end_s = (cnt_r <= STRB_MIN_CNT) && (!bus.cont_n || (cnt_r == 8'd0));
    state_s    = state_r;
    cnt_s      = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ADDR_LO;
          cnt_s   = LOAD_ADDR_LO;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = 8'd0;
        end
      end
      ST_ADDR_LO: begin
        if (cnt_r == 8'd0) begin
          state_s = ST_ADDR_HI;
          cnt_s   = LOAD_ADDR_HI;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      ST_ADDR_HI: begin
        if (cnt_r == 8'd0) begin
          state_s = ST_STRB;
          cnt_s   = LOAD_STRB;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      ST_STRB: begin
        if (strb_end_s) begin
          state_s = ST_RECOVER;
          cnt_s   = LOAD_RECOVER;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_r == 8'd0) begin
          state_s = ST_IDLE;
          cnt_s   = 8'd0;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Request fields are captured on acceptance and held for the whole cycle.
  always_comb begin
    if (accept_s) begin
      aio_s   = req_aio;
      bs_s    = req_bs;
      addr_s  = req_addr;
      wdata_s = req_wdata;
    end else begin
      aio_s   = aio_r;
      bs_s    = bs_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
    end
  end

  // Pin values for the state being entered, so every pin is a flop output.
  always_comb begin
    dal_o_s    = 16'h0000;
    dal_oe_s   = 1'b0;
    aio_o_s    = AIO_NIO;
    ale_n_s    = 1'b1;
    sctl_n_s   = 1'b1;
    bufctl_n_s = 1'b1;
    case (state_s)
      ST_ADDR_LO: begin
        ale_n_s  = 1'b0;
        dal_oe_s = 1'b1;
        dal_o_s  = addr_s[15:0];
        aio_o_s  = aio_s;
      end
      ST_ADDR_HI: begin
        ale_n_s  = 1'b0;
        dal_oe_s = 1'b1;
        dal_o_s  = pack_addr_hi(addr_s, bs_s);
        aio_o_s  = aio_s;
      end
      ST_STRB: begin
        ale_n_s  = 1'b0;
        sctl_n_s = 1'b0;
        aio_o_s  = aio_s;
        if (aio_s[3]) begin
          bufctl_n_s = 1'b0;
        end else begin
          dal_oe_s = 1'b1;
          dal_o_s  = wdata_s;
        end
      end
      default: begin
        dal_o_s = 16'h0000;
      end
    endcase
  end

  // State, captured request, bus pins and response registers.
  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      aio_r        <= AIO_NIO;
      bs_r         <= BS_MEM;
      addr_r       <= 22'd0;
      wdata_r      <= 16'h0000;
      req_ready    <= 1'b0;
      dal_o_r      <= 16'h0000;
      dal_oe_r     <= 1'b0;
      aio_o_r      <= AIO_NIO;
      ale_n_r      <= 1'b1;
      sctl_n_r     <= 1'b1;
      bufctl_n_r   <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= 16'h0000;
      resp_nxm     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      aio_r      <= aio_s;
      bs_r       <= bs_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      req_ready  <= (state_s == ST_IDLE);
      dal_o_r    <= dal_o_s;
      dal_oe_r   <= dal_oe_s;
      aio_o_r    <= aio_o_s;
      ale_n_r    <= ale_n_s;
      sctl_n_r   <= sctl_n_s;
      bufctl_n_r <= bufctl_n_s;
      if ((state_r == ST_STRB) && strb_end_s) begin
        resp_valid   <= 1'b1;
        resp_rdata   <= aio_r[3] ? bus.dal_i : 16'h0000;
        resp_nxm     <= ~bus.nxm_n;
        resp_timeout <= bus.cont_n;
      end else begin
        resp_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_j11_bus_initiator.sv
// Scoreboard bench for j11_bus_initiator with a small behavioural responder
// (RAM below HIMEM, XCSR, GP power-up word, NXM, programmable cont_n wait).
module tb_j11_bus_initiator;

  localparam logic [21:0] HIMEM = 22'o10000000;

  logic        clk_x3 = 1'b0;
  logic        rstb;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_aio;
  logic [1:0]  req_bs;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_nxm;
  logic        resp_timeout;

  j11_bus_initiator_if bus_if();

  j11_bus_initiator dut (
    .clk_x3      (clk_x3),
    .rstb        (rstb),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_aio     (req_aio),
    .req_bs      (req_bs),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_nxm    (resp_nxm),
    .resp_timeout(resp_timeout),
    .bus         (bus_if)
  );

  always #5 clk_x3 = ~clk_x3;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0] rdata;
    logic        nxm;
    logic        tmo;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  aio;
    int          slen;
    logic        wr;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb[$];

  // Responder state captured from the bus
  logic [15:0] ram [0:255];
  logic [15:0] cap_lo = 16'h0000;
  logic [15:0] cap_hi = 16'h0000;
  logic [15:0] cap_wdata = 16'h0000;
  logic [3:0]  cap_aio = 4'hF;
  logic        in_addr = 1'b0;
  int          strb_seen = 0;
  int          cont_hold = 0;
  int          cyc = 0;
  int          accept_cyc = 0;

  always @(posedge clk_x3) begin
    cyc <= cyc + 1;
    if (!bus_if.ale_n && bus_if.sctl_n && bus_if.dal_oe) begin
      if (!in_addr) begin
        cap_lo  <= bus_if.dal_o;
        cap_aio <= bus_if.aio_o;
      end
      cap_hi  <= bus_if.dal_o;
      in_addr <= 1'b1;
    end else begin
      in_addr <= 1'b0;
    end
    if (!bus_if.sctl_n) strb_seen <= strb_seen + 1;
    else strb_seen <= 0;
    if (!bus_if.sctl_n && bus_if.dal_oe && !bus_if.aio_o[3]) begin
      ram[cap_lo[8:1]] <= bus_if.dal_o;
      cap_wdata        <= bus_if.dal_o;
    end
  end

  logic [21:0] dec_addr;
  logic [1:0]  dec_bs;
  logic        dec_nxm;
  logic [15:0] rd_word;

  always_comb begin
    dec_addr = {cap_hi[8], cap_hi[0], cap_hi[9], cap_hi[10], cap_hi[11], cap_hi[12], cap_lo};
    dec_bs   = cap_hi[7:6];
    dec_nxm  = (dec_bs == 2'b00) && (dec_addr >= HIMEM);
    if (cap_aio == 4'b1110) rd_word = (cap_lo[7:0] == 8'o000) ? 16'h0003 : 16'h0000;
    else if (dec_nxm) rd_word = 16'h0000;
    else if ((dec_bs == 2'b10) && (cap_lo == 16'o177564)) rd_word = 16'o000200;
    else if (dec_bs == 2'b00) rd_word = ram[cap_lo[8:1]];
    else rd_word = 16'h0000;
  end

  assign bus_if.dal_i  = !bus_if.bufctl_n ? rd_word : 16'hA5A5;
  assign bus_if.cont_n = (!bus_if.sctl_n && (strb_seen < cont_hold));
  assign bus_if.nxm_n  = !(!bus_if.sctl_n && dec_nxm);

  // Response monitor and bus-integrity checks
  always @(negedge clk_x3) begin : mon
    exp_t e;
    if (!bus_if.bufctl_n) check_val("dal_contention", {31'd0, bus_if.dal_oe}, 32'd0);
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_resp", {31'd0, resp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
        check_val("nxm", {31'd0, resp_nxm}, {31'd0, e.nxm});
        check_val("timeout", {31'd0, resp_timeout}, {31'd0, e.tmo});
        check_val("addr_lo", {16'd0, cap_lo}, {16'd0, e.lo});
        check_val("addr_hi", {16'd0, cap_hi}, {16'd0, e.hi});
        check_val("aio", {28'd0, cap_aio}, {28'd0, e.aio});
        check_val("strobe_len", strb_seen, e.slen);
        check_val("recover_bus", {24'd0, bus_if.aio_o, bus_if.ale_n, bus_if.sctl_n,
                  bus_if.bufctl_n, bus_if.dal_oe}, {24'd0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0});
        if (e.wr) check_val("wdata", {16'd0, cap_wdata}, {16'd0, e.wdata});
      end
    end
  end

  task automatic issue(input logic [3:0] aio, input logic [1:0] bs, input logic [21:0] addr,
                       input logic [15:0] wdata, input logic [15:0] e_rdata, input logic e_nxm,
                       input logic e_tmo, input int e_slen, input bit expect_resp);
    exp_t e;
    int n;
    e.rdata = e_rdata;
    e.nxm   = e_nxm;
    e.tmo   = e_tmo;
    e.lo    = addr[15:0];
    e.hi    = {3'b000, addr[16], addr[17], addr[18], addr[19], addr[21], bs[1], bs[0], 5'b00000, addr[20]};
    e.aio   = aio;
    e.slen  = e_slen;
    e.wr    = !aio[3];
    e.wdata = wdata;
    if (expect_resp) sb.push_back(e);
    req_aio   = aio;
    req_bs    = bs;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk_x3);
      n++;
    end
    if (!req_ready) begin
      check_val("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk_x3);
      #1;
      accept_cyc = cyc;
      req_valid  = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk_x3);
      n++;
    end
    if (sb.size() != 0) begin
      check_val("resp_wait", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int a1;
    int n;
    rstb = 1'b1;
    req_valid = 1'b0;
    req_aio = 4'hF;
    req_bs = 2'b00;
    req_addr = 22'd0;
    req_wdata = 16'h0000;
    repeat (3) @(negedge clk_x3);
    check_val("rst_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_resp", {13'd0, resp_valid, resp_nxm, resp_timeout, resp_rdata}, 32'd0);
    check_val("rst_dal", {15'd0, bus_if.dal_oe, bus_if.dal_o}, 32'd0);
    check_val("rst_ctl", {25'd0, bus_if.aio_o, bus_if.ale_n, bus_if.sctl_n, bus_if.bufctl_n}, 32'h7F);
    rstb = 1'b0;
    @(negedge clk_x3);
    check_val("idle_ready", {31'd0, req_ready}, 32'd1);

    // Word write then back-to-back read-back: accept interval is 11 cycles
    issue(4'b0001, 2'b00, 22'o001000, 16'o123456, 16'h0000, 1'b0, 1'b0, 4, 1'b1);
    a1 = accept_cyc;
    issue(4'b1001, 2'b00, 22'o001000, 16'h0000, 16'o123456, 1'b0, 1'b0, 4, 1'b1);
    check_val("b2b_interval", accept_cyc - a1, 11);
    drain();

    issue(4'b1001, 2'b10, 22'o17777564, 16'h0000, 16'o000200, 1'b0, 1'b0, 4, 1'b1);
    drain();
    issue(4'b1001, 2'b00, 22'o17760000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4, 1'b1);
    drain();
    issue(4'b1110, 2'b00, 22'o000000, 16'h0000, 16'h0003, 1'b0, 1'b0, 4, 1'b1);
    drain();
    issue(4'b0011, 2'b00, 22'o001002, 16'o000377, 16'h0000, 1'b0, 1'b0, 4, 1'b1);
    drain();
    issue(4'b1111, 2'b00, 22'o001000, 16'h0000, 16'o123456, 1'b0, 1'b0, 4, 1'b1);
    drain();

    cont_hold = 10;
    issue(4'b1001, 2'b10, 22'o17777564, 16'h0000, 16'o000200, 1'b0, 1'b0, 11, 1'b1);
    drain();
    cont_hold = 100;
    issue(4'b1001, 2'b10, 22'o17777564, 16'h0000, 16'o000200, 1'b0, 1'b1, 64, 1'b1);
    drain();
    cont_hold = 0;

    // Reset in the second strobe cycle abandons the cycle without a response
    issue(4'b1110, 2'b00, 22'o000000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
    n = 0;
    while (bus_if.sctl_n && n < 20) begin
      @(negedge clk_x3);
      n++;
    end
    check_val("strobe_reached", {31'd0, bus_if.sctl_n}, 32'd0);
    @(negedge clk_x3);
    rstb = 1'b1;
    @(negedge clk_x3);
    check_val("midrst_bus", {28'd0, bus_if.ale_n, bus_if.sctl_n, bus_if.bufctl_n, bus_if.dal_oe}, 32'hE);
    check_val("midrst_resp", {31'd0, resp_valid}, 32'd0);
    rstb = 1'b0;
    repeat (3) @(negedge clk_x3);
    issue(4'b1001, 2'b10, 22'o17777564, 16'h0000, 16'o000200, 1'b0, 1'b0, 4, 1'b1);
    drain();
    repeat (4) @(negedge clk_x3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
